// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the multi-precision carry-skip add sequencer.
package csa_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 8;

   // Slice index width; a single-slice build still needs a one-bit index.
   function automatic int idx_width(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/csa8_core.sv
// Combinational 8-bit carry-skip adder: two 4-bit ripple blocks with skip muxes.
module csa8_core
   import csa_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   localparam int BLK_W = 4;
   localparam int NBLK  = SLICE_W / BLK_W;

   // Ripple within each block; a fully-propagating block forwards its carry-in directly.
   always_comb begin
      logic [SLICE_W-1:0] sum_v;
      logic               blk_cin_v;
      logic               rip_v;
      logic               prop_v;
      sum_v     = '0;
      blk_cin_v = cin;
      for (int k = 0; k < NBLK; k++) begin
         rip_v  = blk_cin_v;
         prop_v = 1'b1;
         for (int j = 0; j < BLK_W; j++) begin
            sum_v[k*BLK_W+j] = a[k*BLK_W+j] ^ b[k*BLK_W+j] ^ rip_v;
            prop_v           = prop_v & (a[k*BLK_W+j] ^ b[k*BLK_W+j]);
            rip_v            = (a[k*BLK_W+j] & b[k*BLK_W+j]) |
                               (rip_v & (a[k*BLK_W+j] ^ b[k*BLK_W+j]));
         end
         blk_cin_v = prop_v ? blk_cin_v : rip_v;
      end
      sum  = sum_v;
      cout = blk_cin_v;
   end

endmodule

// File: rtl/csa_word_sequencer.sv
// Wide add built from one shared 8-bit carry-skip adder, one slice per cycle, LSB first.
// Optional signed-overflow output enabled by defining CSA_SEQ_OVF_EN.
module csa_word_sequencer
   import csa_seq_pkg::*;
#(
   parameter int NSLICE = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*NSLICE-1:0]     in_a,
   input  logic [8*NSLICE-1:0]     in_b,
   input  logic                    in_cin,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*NSLICE-1:0]     out_sum,
   output logic                    out_cout,
   output logic                    busy
`ifdef CSA_SEQ_OVF_EN
   ,
   output logic                    out_ovf
`endif
);

   localparam int WIDTH = SLICE_W * NSLICE;
   localparam int IW    = idx_width(NSLICE);
   localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

   state_t             state_r;
   logic [WIDTH-1:0]   opa_r;
   logic [WIDTH-1:0]   opb_r;
   logic [WIDTH-1:0]   acc_r;
   logic               carry_r;
   logic [IW-1:0]      idx_r;

   logic [SLICE_W-1:0] a_slice_s;
   logic [SLICE_W-1:0] b_slice_s;
   logic [SLICE_W-1:0] sum_s;
   logic               cout_s;
   logic [WIDTH-1:0]   next_acc_s;

   // Select the current operand slice and merge the adder result into the accumulator image.
   always_comb begin
      a_slice_s  = '0;
      b_slice_s  = '0;
      next_acc_s = acc_r;
      for (int i = 0; i < NSLICE; i++) begin
         a_slice_s = a_slice_s | ((idx_r == IW'(i)) ? opa_r[SLICE_W*i +: SLICE_W] : 8'h00);
         b_slice_s = b_slice_s | ((idx_r == IW'(i)) ? opb_r[SLICE_W*i +: SLICE_W] : 8'h00);
         next_acc_s[SLICE_W*i +: SLICE_W] = (idx_r == IW'(i)) ? sum_s
                                           : acc_r[SLICE_W*i +: SLICE_W];
      end
   end

   csa8_core u_core (
      .a    (a_slice_s),
      .b    (b_slice_s),
      .cin  (carry_r),
      .sum  (sum_s),
      .cout (cout_s)
   );

`ifdef CSA_SEQ_OVF_EN
   logic ovf_s;
   // Carry into the MSB is recovered from the MSB sum bit, then XORed with the carry out.
   always_comb begin
      ovf_s = a_slice_s[SLICE_W-1] ^ b_slice_s[SLICE_W-1] ^ sum_s[SLICE_W-1] ^ cout_s;
   end
`endif

   // Sequencer FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         opa_r     <= '0;
         opb_r     <= '0;
         acc_r     <= '0;
         carry_r   <= 1'b0;
         idx_r     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         busy      <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
         out_ovf   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready) begin
                  opa_r    <= in_a;
                  opb_r    <= in_b;
                  carry_r  <= in_cin;
                  idx_r    <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state_r  <= RUN;
               end
            end
            RUN: begin
               acc_r   <= next_acc_s;
               carry_r <= cout_s;
               idx_r   <= idx_r + IW'(1);
               // Publish only the complete word so consumers never see partial slices.
               if (idx_r == LAST_IDX) begin
                  idx_r     <= '0;
                  out_sum   <= next_acc_s;
                  out_cout  <= cout_s;
                  out_valid <= 1'b1;
`ifdef CSA_SEQ_OVF_EN
                  out_ovf   <= ovf_s;
`endif
                  state_r   <= DONE;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               idx_r     <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_word_sequencer.sv
// Directed self-checking bench for csa_word_sequencer (NSLICE=4, 32-bit words).
module tb_csa_word_sequencer;

   localparam int NSLICE = 4;
   localparam int WIDTH  = 8 * NSLICE;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             busy;
`ifdef CSA_SEQ_OVF_EN
   logic             out_ovf;
`endif

   int checks;
   int errors;

   csa_word_sequencer #(.NSLICE(NSLICE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
`ifdef CSA_SEQ_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic get_ovf();
`ifdef CSA_SEQ_OVF_EN
      return out_ovf;
`else
      return 1'b0;
`endif
   endfunction

   // Stimulus only: one transaction, holding out_ready low for 'stall' cycles after out_valid.
   task automatic do_add(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input int stall, output logic [31:0] s, output logic co,
                         output logic ov, output int lat, output bit to);
      int n;
      to = 1'b0; lat = 0; n = 0;
      s = 32'h0; co = 1'b0; ov = 1'b0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (in_ready !== 1'b1) to = 1'b1;
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = 32'hDEADBEEF; in_b = 32'hCAFEF00D; in_cin = 1'b1;
      while (!to) begin
         @(posedge clk); #1; lat++;
         if (out_valid === 1'b1) break;
         if (lat > 50) to = 1'b1;
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
      end
      s = out_sum; co = out_cout; ov = get_ovf();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; in_cin = 1'b0; out_ready = 1'b0;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
      end
      checks++;
      if (out_sum !== 32'h0 || out_cout !== 1'b0 || get_ovf() !== 1'b0) begin
         errors++;
         $display("FAIL reset_data got sum=%h cout=%b ovf=%b want 0 0 0", out_sum, out_cout, get_ovf());
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_carry_chain();
      logic [31:0] s; logic co; logic ov; int lat; bit to;
      do_add(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, s, co, ov, lat, to);
      checks++;
      if (to || s !== 32'h00000000 || co !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL carry_chain got sum=%h cout=%b ovf=%b to=%0d want 00000000 1 0", s, co, ov, to);
      end
      checks++;
      if (lat != NSLICE) begin
         errors++;
         $display("FAIL carry_latency got %0d want %0d", lat, NSLICE);
      end
   endtask

   task automatic test_vectors();
      logic [31:0] va [4] = '{32'h000000FF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};
      logic [31:0] vb [4] = '{32'h00000001, 32'h80000000, 32'h00000001, 32'h9ABCDEF0};
      logic [31:0] vs [4] = '{32'h00000100, 32'h00000000, 32'h80000000, 32'hACF13568};
      logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic        vo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] s; logic co; logic ov; int lat; bit to;
      for (int i = 0; i < 4; i++) begin
         do_add(va[i], vb[i], 1'b0, 1, s, co, ov, lat, to);
         checks++;
         if (to || s !== vs[i] || co !== vc[i]) begin
            errors++;
            $display("FAIL vector%0d got sum=%h cout=%b to=%0d want %h %b", i, s, co, to, vs[i], vc[i]);
         end
`ifdef CSA_SEQ_OVF_EN
         checks++;
         if (ov !== vo[i]) begin
            errors++;
            $display("FAIL vector%0d_ovf got %b want %b", i, ov, vo[i]);
         end
`else
         if (vo[i] === 1'bx) $display("unexpected x");
`endif
      end
   endtask

   task automatic test_zero();
      logic [31:0] s; logic co; logic ov; int lat; bit to;
      do_add(32'h0, 32'h0, 1'b0, 0, s, co, ov, lat, to);
      checks++;
      if (to || s !== 32'h0 || co !== 1'b0 || ov !== 1'b0 || lat != NSLICE) begin
         errors++;
         $display("FAIL zero got sum=%h cout=%b ovf=%b lat=%0d want 0 0 0 %0d", s, co, ov, lat, NSLICE);
      end
   endtask

   task automatic test_backpressure();
      int n;
      in_a = 32'h11111111; in_b = 32'h22222222; in_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      n = 0;
      // Keep offering junk operands throughout RUN; none may be captured.
      in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_cin = 1'b1;
      while (out_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != NSLICE) begin
         errors++;
         $display("FAIL bp_latency got %0d want %0d", n, NSLICE);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 32'h33333333 || out_cout !== 1'b0 ||
             in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d got valid=%b sum=%h cout=%b in_ready=%b busy=%b want 1 33333333 0 0 1",
                     i, out_valid, out_sum, out_cout, in_ready, busy);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_sum !== 32'h33333333) begin
         errors++;
         $display("FAIL bp_release got valid=%b in_ready=%b busy=%b sum=%h want 0 1 0 33333333",
                  out_valid, in_ready, busy, out_sum);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] s; logic co; logic ov; int lat; bit to;
      in_a = 32'hFFFF0000; in_b = 32'h0001FFFF; in_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          out_sum !== 32'h0 || out_cout !== 1'b0 || get_ovf() !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run got in_ready=%b valid=%b busy=%b sum=%h cout=%b want 1 0 0 0 0",
                  in_ready, out_valid, busy, out_sum, out_cout);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      do_add(32'h0000000A, 32'h00000005, 1'b0, 0, s, co, ov, lat, to);
      checks++;
      if (to || s !== 32'h0000000F || co !== 1'b0 || lat != NSLICE) begin
         errors++;
         $display("FAIL after_reset_add got sum=%h cout=%b lat=%0d want 0000000F 0 %0d", s, co, lat, NSLICE);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a; logic [31:0] b; logic c;
      logic [32:0] exp;
      logic        exp_ov;
      logic [31:0] s; logic co; logic ov; int lat; bit to;
      int bad;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom; b = $urandom; c = 1'($urandom_range(1, 0));
         exp    = {1'b0, a} + {1'b0, b} + {32'h0, c};
         exp_ov = (a[31] == b[31]) && (exp[31] != a[31]);
         do_add(a, b, c, $urandom_range(3, 0), s, co, ov, lat, to);
         checks++;
         if (to || {co, s} !== exp || lat != NSLICE) begin
            errors++; bad++;
            if (bad < 10)
               $display("FAIL rand%0d a=%h b=%h cin=%b got %b_%h lat=%0d want %b_%h",
                        i, a, b, c, co, s, lat, exp[32], exp[31:0]);
         end
`ifdef CSA_SEQ_OVF_EN
         checks++;
         if (ov !== exp_ov) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL rand%0d_ovf got %b want %b", i, ov, exp_ov);
         end
`else
         if (exp_ov === 1'bx) $display("unexpected x");
`endif
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_carry_chain();
      test_vectors();
      test_zero();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
